// File: rtl/imm_id_ctrl.sv
// ID-stage control: decodes immediate and register fields from IF/ID into a
// one-entry ID/EX register, inserts a single bubble on a load-use hazard,
// honours branch flush, and keeps a saturating count of load-use stall cycles.
module imm_id_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_imm,
  output logic [5:0]  out_opcode,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {EMPTY, FULL, STALL} state_t;

  typedef struct packed {
    logic [31:0] imm;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
  } dec_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t state_q, state_n;
  dec_t   ent_q, dec;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt;
  logic [15:0] imm16;
  logic        rt_is_src;
  logic        hazard;
  logic        accept;

  assign opcode = in_instr[31:26];
  assign rs     = in_instr[25:21];
  assign rt     = in_instr[20:16];
  assign imm16  = in_instr[15:0];

  // rt is only a source operand for R-type, branches and stores; for the
  // other I-types it is the destination and cannot create a load-use hazard.
  assign rt_is_src = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                     (opcode == OP_BNE)   || (opcode == OP_SW);

  assign hazard = in_valid && ex_memread && (ex_rt != 5'd0) &&
                  ((ex_rt == rs) || ((ex_rt == rt) && rt_is_src));

  // Reset is folded in so nothing is accepted in a reset cycle.
  assign in_ready = !reset && !flush && !hazard && (state_q != STALL) &&
                    ((state_q == EMPTY) || out_ready);
  assign accept   = in_valid && in_ready;

  // Immediate formation per opcode class.
  always_comb begin
    dec.opcode = opcode;
    dec.rs     = rs;
    dec.rt     = rt;
    dec.imm    = {{16{imm16[15]}}, imm16};
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: dec.imm = {16'h0000, imm16};
      OP_LUI:                   dec.imm = {imm16, 16'h0000};
      OP_RTYPE:                 dec.imm = {27'd0, in_instr[10:6]};
      OP_BEQ, OP_BNE:           dec.imm = {{14{imm16[15]}}, imm16, 2'b00};
      default:                  dec.imm = {{16{imm16[15]}}, imm16};
    endcase
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_n = state_q;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept)      state_n = FULL;
          else if (hazard) state_n = STALL;
          else             state_n = EMPTY;
        end
        FULL: begin
          if (!out_ready)  state_n = FULL;
          else if (accept) state_n = FULL;
          else if (hazard) state_n = STALL;
          else             state_n = EMPTY;
        end
        STALL:   state_n = EMPTY;
        default: state_n = EMPTY;
      endcase
    end
  end

  // State, entry capture on acceptance only, and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      ent_q     <= '0;
      stall_cnt <= 16'd0;
    end else begin
      state_q <= state_n;
      if (accept) ent_q <= dec;
      if ((state_q == STALL) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_imm    = ent_q.imm;
  assign out_opcode = ent_q.opcode;
  assign out_rs     = ent_q.rs;
  assign out_rt     = ent_q.rt;

endmodule

// File: tb/tb_imm_id_ctrl.sv
// Directed bench for imm_id_ctrl with hand-computed expectations.
module tb_imm_id_ctrl;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, ex_memread, flush;
  logic        out_valid, out_ready;
  logic [31:0] in_instr, out_imm;
  logic [4:0]  ex_rt, out_rs, out_rt;
  logic [5:0]  out_opcode;
  logic [15:0] stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  imm_id_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_opcode(out_opcode), .out_rs(out_rs),
    .out_rt(out_rt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // advance one edge, settle outputs
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vin  [4];
  logic [31:0] vimm [4];
  logic [5:0]  vop  [4];

  initial begin
    vin[0] = 32'h3421FFFF; vimm[0] = 32'h0000FFFF; vop[0] = 6'h0D; // ORI
    vin[1] = 32'h3C011234; vimm[1] = 32'h12340000; vop[1] = 6'h0F; // LUI
    vin[2] = 32'h1022FFFF; vimm[2] = 32'hFFFFFFFC; vop[2] = 6'h04; // BEQ
    vin[3] = 32'h00011080; vimm[3] = 32'h00000002; vop[3] = 6'h00; // SLL

    reset = 1; in_valid = 1; in_instr = 32'h2001FFFC; ex_memread = 0;
    ex_rt = 0; flush = 0; out_ready = 1;
    tick(); tick();
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_fields", {16'd0, out_opcode, out_rs, out_rt}, 0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 0);

    // ADDI accept from EMPTY, one-cycle latency
    reset = 0; #1;
    chk("addi_in_ready", {31'd0, in_ready}, 1);
    tick();
    chk("addi_valid", {31'd0, out_valid}, 1);
    chk("addi_imm", out_imm, 32'hFFFFFFFC);
    chk("addi_op", {26'd0, out_opcode}, 32'h08);
    chk("addi_rt", {27'd0, out_rt}, 1);

    // back-to-back immediate formats
    for (int i = 0; i < 4; i++) begin
      in_instr = vin[i]; #1;
      chk("b2b_in_ready", {31'd0, in_ready}, 1);
      tick();
      chk("b2b_imm", out_imm, vimm[i]);
      chk("b2b_op", {26'd0, out_opcode}, {26'd0, vop[i]});
      chk("b2b_valid", {31'd0, out_valid}, 1);
    end

    // drain: entry leaves, fields held
    in_valid = 0;
    tick();
    chk("drain_valid", {31'd0, out_valid}, 0);
    chk("drain_imm_held", out_imm, 32'h2);

    // load-use on rs from EMPTY
    in_valid = 1; in_instr = 32'h00221820; ex_memread = 1; ex_rt = 1; #1;
    chk("haz_in_ready", {31'd0, in_ready}, 0);
    tick();
    ex_memread = 0; #1;
    chk("stall_bubble", {31'd0, out_valid}, 0);
    chk("stall_in_ready", {31'd0, in_ready}, 0);
    tick();
    chk("stall_cnt1", {16'd0, stall_cnt}, 1);
    chk("post_stall_valid", {31'd0, out_valid}, 0);
    chk("post_stall_ready", {31'd0, in_ready}, 1);
    tick();
    chk("add_valid", {31'd0, out_valid}, 1);
    chk("add_fields", {16'd0, out_opcode, out_rs, out_rt}, {16'd0, 6'h00, 5'd1, 5'd2});

    // ex_rt=0 never hazards
    ex_memread = 1; ex_rt = 0; #1;
    chk("rt0_in_ready", {31'd0, in_ready}, 1);
    tick();
    chk("rt0_stall_cnt", {16'd0, stall_cnt}, 1);

    // rt match on non-source I-type: no hazard
    in_instr = 32'h20020005; ex_rt = 2; #1;
    chk("itype_rt_ready", {31'd0, in_ready}, 1);
    tick();
    chk("itype_rt_imm", out_imm, 32'h5);

    // backpressure for 3 cycles, then back-to-back accept
    ex_memread = 0; out_ready = 0; in_instr = 32'h3421FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      tick();
      chk("bp_valid", {31'd0, out_valid}, 1);
      chk("bp_imm", out_imm, 32'h5);
    end
    out_ready = 1; #1;
    chk("bp_release_ready", {31'd0, in_ready}, 1);
    tick();
    chk("bp_new_imm", out_imm, 32'h0000FFFF);
    chk("bp_new_valid", {31'd0, out_valid}, 1);

    // flush in FULL drops incoming
    flush = 1; in_instr = 32'h3C011234; #1;
    chk("flush_in_ready", {31'd0, in_ready}, 0);
    tick();
    flush = 0; in_valid = 0;
    chk("flush_valid", {31'd0, out_valid}, 0);
    chk("flush_no_capture", out_imm, 32'h0000FFFF);

    // FULL -> STALL on hazard while draining
    in_valid = 1; in_instr = 32'h2001FFFC;
    tick();
    chk("refill_valid", {31'd0, out_valid}, 1);
    in_instr = 32'h00221820; ex_memread = 1; ex_rt = 1;
    tick();
    chk("full_stall_valid", {31'd0, out_valid}, 0);
    ex_memread = 0;
    tick();
    chk("stall_cnt2", {16'd0, stall_cnt}, 2);
    tick();
    chk("full_stall_accept", {31'd0, out_valid}, 1);

    // reset together with flush while FULL
    reset = 1; flush = 1; #1;
    chk("rst_flush_ready", {31'd0, in_ready}, 0);
    tick();
    chk("rst_flush_valid", {31'd0, out_valid}, 0);
    chk("rst_flush_imm", out_imm, 0);
    chk("rst_flush_fields", {16'd0, out_opcode, out_rs, out_rt}, 0);
    chk("rst_flush_cnt", {16'd0, stall_cnt}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
